// File: rtl/credit_sender_pkg.sv
// Shared types and helpers for the credit-based link sender.
package credit_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} credit_state_t;

  // Wide enough to hold the full credit ceiling, including the value MAX itself.
  function automatic int calc_cnt_w(input int max_credits);
    return $clog2(max_credits + 1);
  endfunction
endpackage

// File: rtl/credit_sender_if.sv
// Upstream valid/ready, downstream valid-only data and credit-return signals.
interface credit_sender_if #(
  parameter int DATA_W = 32
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              credit_ret;

  modport master (
    output in_valid, in_data, credit_ret,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, credit_ret,
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/credit_sender_counter.sv
// Credit counter: load to MAX, up/down on return/send, saturates and flags bad returns.
module credit_counter
  import credit_pkg::*;
#(
  parameter int CNT_W = 3,
  parameter int MAX   = 4
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic             active,
  input  logic             dec,
  input  logic             inc,
  output logic [CNT_W-1:0] count_o,
  output logic             overflow_o
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX);
  localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    count_d = count_q;
    ovf_d   = ovf_q;
    if (load) begin
      count_d = MAX_C;
    end else if (active) begin
      if (dec && !inc) begin
        count_d = count_q - ONE_C;
      end else if (inc && !dec) begin
        // The receiver cannot free more entries than it has.
        if (count_q == MAX_C) ovf_d = 1'b1;
        else                  count_d = count_q + ONE_C;
      end
    end
    if (inc && !active) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count_o    = count_q;
  assign overflow_o = ovf_q;
endmodule

// File: rtl/credit_sender.sv
// Transmit end of the credit link: FSM, handshake and registered output word.
module credit_sender
  import credit_pkg::*;
#(
  parameter int  DATA_W      = 32,
  parameter int  MAX_CREDITS = 4,
  localparam int CNT_W       = calc_cnt_w(MAX_CREDITS)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             start,
  input  logic             flush,
  credit_sender_if.slave   bus,
  output logic [CNT_W-1:0] credits,
  output logic             drained,
  output logic             overflow_err
);
  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CREDITS);

  credit_state_t     state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] out_data_q;
  logic              drained_q;
  logic              send;
  logic              load;
  logic              active;

  // Ready depends only on registered state, never on in_valid.
  assign bus.in_ready = (state_q == RUN) && (credits != '0);
  assign send         = bus.in_valid && bus.in_ready;
  assign load         = (state_q == IDLE) && start;
  assign active       = (state_q != IDLE);

  credit_counter #(
    .CNT_W (CNT_W),
    .MAX   (MAX_CREDITS)
  ) u_counter (
    .clk        (CLK),
    .srst       (RST),
    .load       (load),
    .active     (active),
    .dec        (send),
    .inc        (bus.credit_ret),
    .count_o    (credits),
    .overflow_o (overflow_err)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      drained_q   <= 1'b0;
    end else begin
      out_valid_q <= send;
      if (send) out_data_q <= bus.in_data;
      drained_q <= 1'b0;
      case (state_q)
        IDLE:    if (start) state_q <= RUN;
        RUN:     if (flush) state_q <= DRAIN;
        DRAIN: begin
          if (credits == MAX_C) begin
            state_q   <= IDLE;
            drained_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign drained       = drained_q;
endmodule

// File: doc/credit_sender.md
Name: credit_sender

Overview:
Transmit end of the team's credit-based flow-control link. It is the sender-side counterpart of the up/down occupancy counting used by the receiving buffers.
- Accepts words from an upstream valid/ready producer and forwards them downstream with no back-pressure wire.
- Sending is limited by a local credit count that decrements on each send and increments on each credit-return pulse from the receiver.
- Sits between a pipeline stage or bus master and a remote receive FIFO of depth MAX_CREDITS.

Parameters:
DATA_W, 32, width of data word
MAX_CREDITS, 4, receiver buffer depth; credit count ceiling (1..255)
CNT_W, $clog2(MAX_CREDITS+1), credit counter width (derived, not overridden)

Ports:
CLK  input  1  system clock, rising-edge
RST  input  1  synchronous, active-high reset
start  input  1  pulse; IDLE->RUN, loads credits = MAX_CREDITS
flush  input  1  pulse; RUN->DRAIN, stop accepting, wait for all credits back
in_valid  input  1  upstream word valid
in_data  input  DATA_W  upstream word
in_ready  output  1  sender can accept this cycle
out_valid  output  1  registered; downstream word valid (one word per pulse)
out_data  output  DATA_W  registered downstream word
credit_ret  input  1  pulse; receiver freed one entry
credits  output  CNT_W  current credit count
drained  output  1  one-cycle pulse on DRAIN->IDLE
overflow_err  output  1  sticky; illegal credit return seen

Behaviour:
- Interface: one clock CLK; reset RST is synchronous and active-high. All state updates on the CLK rising edge.
- Reset values: state=IDLE, credits=0, out_valid=0, out_data=0, drained=0, overflow_err=0.
- A reset asserted mid-operation discards in-flight state immediately. No drain is performed.
- States: IDLE, RUN, DRAIN.
  - IDLE: start -> RUN with credits <= MAX_CREDITS.
  - RUN: flush -> DRAIN. If start and flush are both asserted in RUN, flush wins.
  - DRAIN: when credits == MAX_CREDITS (evaluated on the registered value) -> IDLE, and drained=1 for the following cycle.
  - start is ignored outside IDLE. flush is ignored outside RUN.
- in_ready = (state==RUN) && (credits != 0). It is combinational from registered state only and never depends on in_valid.
- A send fires when in_valid && in_ready.
  - Next cycle: out_valid=1 and out_data=in_data (latency 1).
  - When no send fires, out_valid=0 next cycle and out_data holds its value.
- Credit update per cycle:
  - send only: -1.
  - return only: +1.
  - send and return together: unchanged.
  - A send cannot occur at 0 because in_ready is low. A return at 0 makes the count 1, and the sender may send again on the next cycle.
- Saturation and errors:
  - A return when credits == MAX_CREDITS with no simultaneous send sets overflow_err and holds the count at MAX_CREDITS.
  - A return in IDLE sets overflow_err and leaves credits unchanged.
  - overflow_err clears only on RST.
- Throughput: one word per cycle while credits > 0. Sustained rate equals the credit-return rate once credits are exhausted.
- Arithmetic is unsigned CNT_W bits. There is no wrap-around in either direction because of the guards above.

Decomposition:
- Package credit_pkg holds:
  - typedef enum logic [1:0] {IDLE, RUN, DRAIN} credit_state_t
  - a localparam function for the CNT_W computation.
- Sub-module credit_counter (parameter CNT_W, MAX) holds the load/inc/dec/saturate logic and the overflow detect.
- The top level holds the FSM, the handshake logic and the output register.

Test Plan:
1. Reset, then start, with MAX_CREDITS=4: 4 back-to-back in_valid words A..D are all accepted. out_valid is high in cycles 1..4, credits go 3,2,1,0, and in_ready=0 after D.
2. With credits=0 and in_valid held: no output. A single credit_ret pulse gives credits=1 and in_ready=1 next cycle; exactly one word goes out, then credits=0.
3. credits=2, in_valid and credit_ret together for 3 cycles -> credits stays 2 and 3 words are output.
4. RUN with credits=1, flush -> DRAIN with in_ready=0. Three credit_ret pulses -> credits=4, drained pulses once, state=IDLE, and a subsequent in_valid is not accepted.
5. credits=4 in RUN plus a credit_ret -> overflow_err=1 and credits stays 4. Also check credit_ret in IDLE sets overflow_err; it stays set until RST.
6. RST asserted mid-stream with credits=2 and out_valid=1 -> on the next edge all outputs equal their reset values, and start afterwards restores credits=4.
